// File: rtl/host_bus_arbiter.sv
`timescale 1ns/1ps
// Arbitrates the peripheral register bus between the synchronized async host port and an
// internal req/gnt master. Define ARB_HOST_PRIO_EN for fixed host priority instead of round-robin.
module host_bus_arbiter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic              host_CEb,
    input  logic              host_OEb,
    input  logic              host_WEb,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_din,
    output logic [DATA_W-1:0] host_dout,
    output logic              host_doe,
    output logic              host_ovr,
    input  logic              ovr_clr,
    input  logic              int_req,
    input  logic              int_we,
    input  logic [ADDR_W-1:0] int_addr,
    input  logic [DATA_W-1:0] int_wdata,
    output logic              int_gnt,
    output logic [DATA_W-1:0] int_rdata,
    output logic              int_rvalid,
    output logic [ADDR_W-1:0] per_addr,
    output logic [DATA_W-1:0] per_wdata,
    output logic              per_we,
    output logic              per_re,
    input  logic [DATA_W-1:0] per_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StRdWait} state_e;
    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] ce_sync_q, oe_sync_q, we_sync_q;
    logic                   oe_hist_q, we_hist_q;
    logic                   ce_s, oe_s, we_s, wr_commit, rd_commit;

    logic              wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              host_ovr_q, host_ovr_d;
    logic              cur_host_q, cur_host_d, cur_we_q, cur_we_d;
    logic              host_req, host_win, start, sel_we, clr_wr, clr_rd;

    logic [ADDR_W-1:0] per_addr_q, per_addr_d;
    logic [DATA_W-1:0] per_wdata_q, per_wdata_d, host_dout_q, host_dout_d;
    logic [DATA_W-1:0] int_rdata_q, int_rdata_d;
    logic              per_we_q, per_we_d, per_re_q, per_re_d;
    logic              int_gnt_q, int_gnt_d, int_rvalid_q, int_rvalid_d;

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            ce_sync_q <= '1;
            oe_sync_q <= '1;
            we_sync_q <= '1;
            oe_hist_q <= 1'b1;
            we_hist_q <= 1'b1;
        end else begin
            ce_sync_q <= {ce_sync_q[SYNC_STAGES-2:0], host_CEb};
            oe_sync_q <= {oe_sync_q[SYNC_STAGES-2:0], host_OEb};
            we_sync_q <= {we_sync_q[SYNC_STAGES-2:0], host_WEb};
            oe_hist_q <= oe_s;
            we_hist_q <= we_s;
        end
    end

    assign ce_s      = ce_sync_q[SYNC_STAGES-1];
    assign oe_s      = oe_sync_q[SYNC_STAGES-1];
    assign we_s      = we_sync_q[SYNC_STAGES-1];
    assign wr_commit = ~ce_s & we_s & ~we_hist_q;
    assign rd_commit = ~ce_s & ~oe_s & oe_hist_q;
    assign host_doe  = ~ce_s & ~oe_s;

    assign host_req = wr_pend_q | rd_pend_q;
    assign start    = (state_q == StIdle) & (host_req | int_req);
    assign sel_we   = host_win ? wr_pend_q : int_we;
    assign clr_wr   = (state_q == StIssue) & cur_host_q & cur_we_q;
    assign clr_rd   = (state_q == StIssue) & cur_host_q & ~cur_we_q;

`ifdef ARB_HOST_PRIO_EN
    assign host_win = host_req;
`else
    logic last_host_q;
    assign host_win = host_req & (~int_req | ~last_host_q);

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn)    last_host_q <= 1'b0;
        else if (start) last_host_q <= host_win;
    end
`endif

    // A commit in the same cycle as its flag is cleared keeps the flag set and is not an overrun.
    always_comb begin
        wr_pend_d = wr_pend_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        if (clr_wr) wr_pend_d = 1'b0;
        if (clr_rd) rd_pend_d = 1'b0;
        if (wr_commit) begin
            wr_pend_d = 1'b1;
            wr_addr_d = host_addr;
            wr_data_d = host_din;
        end
        if (rd_commit) begin
            rd_pend_d = 1'b1;
            rd_addr_d = host_addr;
        end
        host_ovr_d = (wr_commit & wr_pend_q & ~clr_wr) | (rd_commit & rd_pend_q & ~clr_rd)
                   | (host_ovr_q & ~ovr_clr);
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StIssue;
            StIssue:  state_d = cur_we_q ? StIdle : StRdWait;
            StRdWait: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Host command is taken from the *_d values so a replacement committed on the grant edge wins.
    always_comb begin
        per_addr_d   = per_addr_q;
        per_wdata_d  = per_wdata_q;
        per_we_d     = 1'b0;
        per_re_d     = 1'b0;
        int_gnt_d    = 1'b0;
        host_dout_d  = host_dout_q;
        int_rdata_d  = int_rdata_q;
        int_rvalid_d = 1'b0;
        cur_host_d   = cur_host_q;
        cur_we_d     = cur_we_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    cur_host_d = host_win;
                    cur_we_d   = sel_we;
                    per_we_d   = sel_we;
                    per_re_d   = ~sel_we;
                    int_gnt_d  = ~host_win;
                    if (host_win) per_addr_d = wr_pend_q ? wr_addr_d : rd_addr_d;
                    else          per_addr_d = int_addr;
                    if (sel_we)   per_wdata_d = host_win ? wr_data_d : int_wdata;
                end
            end
            StRdWait: begin
                if (cur_host_q) begin
                    host_dout_d = per_rdata;
                end else begin
                    int_rdata_d  = per_rdata;
                    int_rvalid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            wr_pend_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            host_ovr_q   <= 1'b0;
            cur_host_q   <= 1'b0;
            cur_we_q     <= 1'b0;
            per_addr_q   <= '0;
            per_wdata_q  <= '0;
            per_we_q     <= 1'b0;
            per_re_q     <= 1'b0;
            int_gnt_q    <= 1'b0;
            host_dout_q  <= '0;
            int_rdata_q  <= '0;
            int_rvalid_q <= 1'b0;
        end else begin
            wr_pend_q    <= wr_pend_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_pend_q    <= rd_pend_d;
            rd_addr_q    <= rd_addr_d;
            host_ovr_q   <= host_ovr_d;
            cur_host_q   <= cur_host_d;
            cur_we_q     <= cur_we_d;
            per_addr_q   <= per_addr_d;
            per_wdata_q  <= per_wdata_d;
            per_we_q     <= per_we_d;
            per_re_q     <= per_re_d;
            int_gnt_q    <= int_gnt_d;
            host_dout_q  <= host_dout_d;
            int_rdata_q  <= int_rdata_d;
            int_rvalid_q <= int_rvalid_d;
        end
    end

    assign host_dout  = host_dout_q;
    assign host_ovr   = host_ovr_q;
    assign int_gnt    = int_gnt_q;
    assign int_rdata  = int_rdata_q;
    assign int_rvalid = int_rvalid_q;
    assign per_addr   = per_addr_q;
    assign per_wdata  = per_wdata_q;
    assign per_we     = per_we_q;
    assign per_re     = per_re_q;

endmodule
